// File: rtl/regfile_wr_arbiter_if.sv
// Bundle between the writeback requesters, decode and the register-file write port.
// The arbiter takes the slave view. Requesters, decode and the bench take the master view.
interface regfile_wr_arbiter_if #(
  parameter int DBITS = 32
);
  logic             aValid;
  logic [3:0]       aRd;
  logic [DBITS-1:0] aData;
  logic             aReady;
  logic             bValid;
  logic [3:0]       bRd;
  logic [DBITS-1:0] bData;
  logic             bReady;
  logic             claimEn;
  logic [3:0]       claimRd;
  logic [3:0]       rs1;
  logic [3:0]       rs2;
  logic             useRs1;
  logic             useRs2;
  logic             hazard;
  logic             wrtEn;
  logic [3:0]       wrtRd;
  logic [DBITS-1:0] wrtData;
  logic [15:0]      busy;

  modport master (
    output aValid, aRd, aData, bValid, bRd, bData,
    output claimEn, claimRd, rs1, rs2, useRs1, useRs2,
    input  aReady, bReady, hazard, wrtEn, wrtRd, wrtData, busy
  );

  modport slave (
    input  aValid, aRd, aData, bValid, bRd, bData,
    input  claimEn, claimRd, rs1, rs2, useRs1, useRs2,
    output aReady, bReady, hazard, wrtEn, wrtRd, wrtData, busy
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for two writeback sources onto the single register-file write port.
// It also holds the pending-write scoreboard that decode uses for RAW stalls.
module regfile_wr_arbiter #(
  parameter int DBITS = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  regfile_wr_arbiter_if.slave   bus
);

  logic             rr_ptr_q, rr_ptr_d;
  logic             wrt_en_q, wrt_en_d;
  logic [3:0]       wrt_rd_q, wrt_rd_d;
  logic [DBITS-1:0] wrt_data_q, wrt_data_d;
  logic [15:0]      busy_q, busy_d;
  logic             grant_a, grant_b;

  // Grants depend only on the valids and the pointer. Gating with reset_n keeps both readies low in reset.
  always_comb begin
    grant_a = reset_n & bus.aValid & (~bus.bValid | ~rr_ptr_q);
    grant_b = reset_n & bus.bValid & (~bus.aValid |  rr_ptr_q);
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wrt_en_d   = grant_a | grant_b;
    wrt_rd_d   = wrt_rd_q;
    wrt_data_d = wrt_data_q;
    if (grant_a) begin
      rr_ptr_d   = 1'b1;
      wrt_rd_d   = bus.aRd;
      wrt_data_d = bus.aData;
    end else if (grant_b) begin
      rr_ptr_d   = 1'b0;
      wrt_rd_d   = bus.bRd;
      wrt_data_d = bus.bData;
    end
  end

  // Clear first, then set, so a younger claim survives a same-cycle commit to the same register.
  always_comb begin
    busy_d = busy_q;
    if (wrt_en_q)
      busy_d[wrt_rd_q] = 1'b0;
    if (bus.claimEn)
      busy_d[bus.claimRd] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= 1'b0;
      wrt_en_q   <= 1'b0;
      wrt_rd_q   <= 4'd0;
      wrt_data_q <= '0;
      busy_q     <= 16'h0000;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wrt_en_q   <= wrt_en_d;
      wrt_rd_q   <= wrt_rd_d;
      wrt_data_q <= wrt_data_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    bus.aReady  = grant_a;
    bus.bReady  = grant_b;
    bus.wrtEn   = wrt_en_q;
    bus.wrtRd   = wrt_rd_q;
    bus.wrtData = wrt_data_q;
    bus.busy    = busy_q;
    bus.hazard  = (bus.useRs1 & busy_q[bus.rs1]) | (bus.useRs2 & busy_q[bus.rs2]);
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter. Inputs change 1 time unit after the rising edge.
// Outputs are sampled 2 time units after the rising edge.
module tb_regfile_wr_arbiter;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  regfile_wr_arbiter_if #(.DBITS(32)) bus ();

  regfile_wr_arbiter #(.DBITS(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.aValid  = 1'b0; bus.aRd = 4'd0; bus.aData = 32'h0;
    bus.bValid  = 1'b0; bus.bRd = 4'd0; bus.bData = 32'h0;
    bus.claimEn = 1'b0; bus.claimRd = 4'd0;
    bus.rs1 = 4'd0; bus.rs2 = 4'd0; bus.useRs1 = 1'b0; bus.useRs2 = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    idle_inputs();

    // Test 1: hold A in reset, then release.
    bus.aValid = 1'b1; bus.aRd = 4'd3; bus.aData = 32'h11;
    step(); step();
    #1;
    check_eq("t1_rst_aReady", 32'(bus.aReady), 32'h0);
    check_eq("t1_rst_wrtEn",  32'(bus.wrtEn),  32'h0);
    check_eq("t1_rst_busy",   32'(bus.busy),   32'h0);
    check_eq("t1_rst_wrtData", bus.wrtData,    32'h0);
    reset_n = 1'b1;
    #1;
    check_eq("t1_aReady", 32'(bus.aReady), 32'h1);
    check_eq("t1_bReady", 32'(bus.bReady), 32'h0);
    step();
    bus.aValid = 1'b0;
    #1;
    check_eq("t1_wrtEn",   32'(bus.wrtEn), 32'h1);
    check_eq("t1_wrtRd",   32'(bus.wrtRd), 32'h3);
    check_eq("t1_wrtData", bus.wrtData,    32'h11);
    step();
    #1;
    check_eq("t1_wrtEn_off", 32'(bus.wrtEn), 32'h0);
    check_eq("t1_wrtRd_hold", 32'(bus.wrtRd), 32'h3);

    // Test 2: both requesters held from reset.
    reset_n = 1'b0;
    bus.aValid = 1'b1; bus.aRd = 4'd5; bus.aData = 32'hA5;
    bus.bValid = 1'b1; bus.bRd = 4'd6; bus.bData = 32'hB6;
    step();
    reset_n = 1'b1;
    #1;
    check_eq("t2_c0_aReady", 32'(bus.aReady), 32'h1);
    check_eq("t2_c0_bReady", 32'(bus.bReady), 32'h0);
    step(); #1;
    check_eq("t2_c1_wrtEn",  32'(bus.wrtEn),  32'h1);
    check_eq("t2_c1_wrtRd",  32'(bus.wrtRd),  32'h5);
    check_eq("t2_c1_wrtData", bus.wrtData,    32'hA5);
    check_eq("t2_c1_aReady", 32'(bus.aReady), 32'h0);
    check_eq("t2_c1_bReady", 32'(bus.bReady), 32'h1);
    step(); #1;
    check_eq("t2_c2_wrtEn",  32'(bus.wrtEn),  32'h1);
    check_eq("t2_c2_wrtRd",  32'(bus.wrtRd),  32'h6);
    check_eq("t2_c2_wrtData", bus.wrtData,    32'hB6);
    check_eq("t2_c2_aReady", 32'(bus.aReady), 32'h1);
    check_eq("t2_c2_bReady", 32'(bus.bReady), 32'h0);
    step();
    bus.aValid = 1'b0; bus.bValid = 1'b0;
    #1;
    check_eq("t2_c3_wrtEn", 32'(bus.wrtEn), 32'h1);
    check_eq("t2_c3_wrtRd", 32'(bus.wrtRd), 32'h5);
    step(); #1;
    check_eq("t2_idle_wrtEn", 32'(bus.wrtEn), 32'h0);

    // Test 3: claim r7, check hazard, then commit a write to r7.
    bus.claimEn = 1'b1; bus.claimRd = 4'd7;
    step();
    bus.claimEn = 1'b0;
    bus.rs1 = 4'd7; bus.useRs1 = 1'b1;
    #1;
    check_eq("t3_busy", 32'(bus.busy), 32'h0080);
    check_eq("t3_hazard_used", 32'(bus.hazard), 32'h1);
    bus.useRs1 = 1'b0;
    #1;
    check_eq("t3_hazard_unused", 32'(bus.hazard), 32'h0);
    bus.useRs1 = 1'b0; bus.rs2 = 4'd7; bus.useRs2 = 1'b1;
    #1;
    check_eq("t3_hazard_rs2", 32'(bus.hazard), 32'h1);
    bus.useRs2 = 1'b0; bus.useRs1 = 1'b1;
    bus.aValid = 1'b1; bus.aRd = 4'd7; bus.aData = 32'h77;
    #1;
    check_eq("t3_aReady", 32'(bus.aReady), 32'h1);
    step();
    bus.aValid = 1'b0;
    #1;
    check_eq("t3_wrtEn", 32'(bus.wrtEn), 32'h1);
    check_eq("t3_wrtRd", 32'(bus.wrtRd), 32'h7);
    check_eq("t3_busy_during_wrt", 32'(bus.busy), 32'h0080);
    check_eq("t3_hazard_during_wrt", 32'(bus.hazard), 32'h1);
    step(); #1;
    check_eq("t3_busy_cleared", 32'(bus.busy), 32'h0);
    check_eq("t3_hazard_cleared", 32'(bus.hazard), 32'h0);
    bus.useRs1 = 1'b0;

    // Test 4a: claim r9, then reclaim r9 in the same cycle its write commits.
    bus.claimEn = 1'b1; bus.claimRd = 4'd9;
    step();
    bus.claimEn = 1'b0;
    bus.aValid = 1'b1; bus.aRd = 4'd9; bus.aData = 32'h99;
    #1;
    check_eq("t4_busy9", 32'(bus.busy), 32'h0200);
    step();
    bus.aValid = 1'b0;
    bus.claimEn = 1'b1; bus.claimRd = 4'd9;
    #1;
    check_eq("t4_wrtEn9", 32'(bus.wrtEn), 32'h1);
    step();
    bus.claimEn = 1'b0;
    #1;
    check_eq("t4_set_wins", 32'(bus.busy), 32'h0200);
    // Test 4b: commit r9 while claiming r2.
    bus.aValid = 1'b1; bus.aRd = 4'd9; bus.aData = 32'h98;
    step();
    bus.aValid = 1'b0;
    bus.claimEn = 1'b1; bus.claimRd = 4'd2;
    #1;
    check_eq("t4_wrtRd9", 32'(bus.wrtRd), 32'h9);
    step();
    bus.claimEn = 1'b0;
    #1;
    check_eq("t4_both_apply", 32'(bus.busy), 32'h0004);

    // Test 5: a grant accepted (rrPtr moves to 1), then reset pulses before the edge.
    bus.aValid = 1'b1; bus.aRd = 4'd4; bus.aData = 32'h44;
    #1;
    check_eq("t5_aReady", 32'(bus.aReady), 32'h1);
    reset_n = 1'b0;
    bus.aValid = 1'b0;
    #1;
    check_eq("t5_busy_async", 32'(bus.busy), 32'h0);
    check_eq("t5_wrtEn_rst", 32'(bus.wrtEn), 32'h0);
    reset_n = 1'b1;
    step(); #1;
    check_eq("t5_no_wrtEn", 32'(bus.wrtEn), 32'h0);
    check_eq("t5_busy_after", 32'(bus.busy), 32'h0);
    bus.aValid = 1'b1; bus.aRd = 4'd5; bus.aData = 32'hA5;
    bus.bValid = 1'b1; bus.bRd = 4'd6; bus.bData = 32'hB6;
    #1;
    check_eq("t5_dual_aReady", 32'(bus.aReady), 32'h1);
    check_eq("t5_dual_bReady", 32'(bus.bReady), 32'h0);
    step();
    bus.aValid = 1'b0;
    #1;
    check_eq("t5_dual_wrtRd", 32'(bus.wrtRd), 32'h5);
    check_eq("t5_b_after_loss", 32'(bus.bReady), 32'h1);
    step();
    bus.bValid = 1'b0;
    #1;
    check_eq("t5_b_wrtRd", 32'(bus.wrtRd), 32'h6);
    step();

    // Test 6: B alone for four cycles with rd 1..4.
    for (int i = 1; i <= 4; i++) begin
      bus.bValid = 1'b1; bus.bRd = 4'(i); bus.bData = 32'h100 + 32'(i);
      #1;
      check_eq("t6_bReady", 32'(bus.bReady), 32'h1);
      check_eq("t6_aReady", 32'(bus.aReady), 32'h0);
      step();
      #1;
      check_eq("t6_wrtEn", 32'(bus.wrtEn), 32'h1);
      check_eq("t6_wrtRd", 32'(bus.wrtRd), 32'(i));
      check_eq("t6_wrtData", bus.wrtData, 32'h100 + 32'(i));
      #(-2 + 2);
      bus.bValid = 1'b0;
    end
    step(); #1;
    check_eq("t6_wrtEn_off", 32'(bus.wrtEn), 32'h0);
    check_eq("t6_wrtRd_hold", 32'(bus.wrtRd), 32'h4);
    check_eq("t6_wrtData_hold", bus.wrtData, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
